m_tag: RTL and testbench
========================

M_TAG -- requirements
Module: m_tag

Interface
REQ-001 Parameter DEPTH, default 4: number of tag entries.
REQ-002 Parameter ADDR_W, default 2: index width; SHALL equal log2(DEPTH).
REQ-003 Parameter TAG_W, default 6: tag entry width.
REQ-004 Port order: clk, address, din, Dwr, Rout, reset, so the block connects positionally in that order.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low; clears all entries.
REQ-008 address  input  ADDR_W  entry index for both read and write.
REQ-009 din  input  TAG_W  tag value to write.
REQ-010 Dwr  input  1  write enable, active-high.
REQ-011 Rout  output  TAG_W  tag stored at address.

Function
REQ-012 Storage SHALL be DEPTH entries of TAG_W bits each.
REQ-013 Write: on a rising clk edge with reset deasserted and Dwr=1, entry[address] SHALL take din.
REQ-014 Dwr=0 at a rising edge SHALL leave all entries unchanged.
REQ-015 Only the addressed entry SHALL change on a write; the other entries hold their values.
REQ-016 Read: Rout SHALL equal entry[address] combinationally, with zero cycles of latency.
REQ-017 Rout SHALL follow any address change within the same cycle, without waiting for a clock edge.
REQ-018 Write then read, same address: Rout SHALL show the new value immediately after the writing edge.
REQ-019 Rout SHALL NOT forward din before that edge.
REQ-020 There is no handshake: a write completes in one cycle, and back-to-back writes on consecutive edges SHALL all take effect.
REQ-021 The full TAG_W range SHALL be stored without truncation: 0 to 2^TAG_W-1, i.e. 0..63 by default.
REQ-022 address covers exactly DEPTH entries; no out-of-range index exists when DEPTH=2^ADDR_W.
REQ-023 Writes to the same address on successive edges: the last write wins.

Reset
REQ-024 While reset=0, every entry SHALL be 0, so Rout=0 for any address.
REQ-025 The clear SHALL take effect immediately on assertion, independent of clk.
REQ-026 A write attempted while reset=0 SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard all previously written tags.
REQ-028 After deassertion, the first rising edge with Dwr=1 SHALL write normally.

Structure
REQ-029 The DEPTH, ADDR_W and TAG_W defaults SHALL live in a shared package, cache_pkg, reused by the cache data and control blocks.
REQ-030 The storage array, write decode and read mux SHALL be implemented inline; no sub-module is required.
REQ-031 The block SHALL elaborate for any DEPTH that is a power of two and any TAG_W of 1 or more.

Verification
REQ-032 Reset scenario: pulse reset low, then sweep address 0,3,1,2 with Dwr=0 -> Rout=0 at every address.
REQ-033 Write/read scenario: address=1, din=9, Dwr=1 for one edge -> Rout=9 after the edge; address=2 -> Rout=0; address=1 -> Rout=9.
REQ-034 No-write scenario: Dwr=0, din=63, clock several edges at address 0 -> Rout stays 0.
REQ-035 Full-array scenario: write 63, 1, 42, 21 to addresses 0..3 on consecutive edges -> reading back returns each value exactly.
REQ-036 Mid-operation reset scenario: after the full-array writes, assert reset between clock edges -> Rout=0 immediately for all addresses; a write attempted during reset leaves Rout=0.
REQ-037 Overwrite scenario: write 5 then 7 to address 3 on successive edges -> Rout=7.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared sizing defaults for the cache tag, data and control blocks.
package cache_pkg;

    localparam int CACHE_DEPTH  = 4;   // number of tag entries
    localparam int CACHE_ADDR_W = 2;   // index width, log2(CACHE_DEPTH)
    localparam int CACHE_TAG_W  = 6;   // width of one tag entry

endpackage : cache_pkg

// File: rtl/m_tag.sv
// Tag store: DEPTH entries of TAG_W bits.
// Writes happen on the rising clock edge. Reads are combinational.
// An active-low asynchronous reset clears every entry.
module m_tag
    import cache_pkg::*;
#(
    parameter int DEPTH  = CACHE_DEPTH,
    parameter int ADDR_W = CACHE_ADDR_W,
    parameter int TAG_W  = CACHE_TAG_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] address,
    input  logic [TAG_W-1:0]  din,
    input  logic              Dwr,
    output logic [TAG_W-1:0]  Rout,
    input  logic              reset
);

    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    // Write decode: only the addressed entry takes din when Dwr is high.
    always_comb begin
        tag_d = tag_q;
        if (Dwr) begin
            tag_d[address] = din;
        end
    end

    // Entry storage. The clear is asynchronous, so Rout drops to 0 as soon as
    // reset goes low, and a write attempted during reset is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q <= '{default: '0};
        end else begin
            tag_q <= tag_d;
        end
    end

    // Read mux. Rout shows only stored contents, so din is never forwarded.
    assign Rout = tag_q[address];

endmodule : m_tag

// File: tb/tb_m_tag.sv
// Directed self-checking bench for m_tag. A reference array tracks the
// expected contents. Each read pushes the expected tag onto a scoreboard,
// then pops it and compares it against Rout.
module tb_m_tag;
    import cache_pkg::*;

    localparam int DEPTH  = CACHE_DEPTH;
    localparam int ADDR_W = CACHE_ADDR_W;
    localparam int TAG_W  = CACHE_TAG_W;

    logic              clk;
    logic [ADDR_W-1:0] address;
    logic [TAG_W-1:0]  din;
    logic              Dwr;
    logic [TAG_W-1:0]  Rout;
    logic              reset;

    logic [TAG_W-1:0] model [DEPTH];
    logic [TAG_W-1:0] sb [$];

    int n_pass;
    int n_total;

    m_tag #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .address (address),
        .din     (din),
        .Dwr     (Dwr),
        .Rout    (Rout),
        .reset   (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expected value and compare it against Rout.
    task automatic compare(input string tag);
        logic [TAG_W-1:0] exp;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL %s: scoreboard empty, Rout=%0d", tag, Rout);
        end else begin
            exp = sb.pop_front();
            assert (Rout === exp) n_pass++;
            else $error("FAIL %s: Rout=%0d expected %0d", tag, Rout, exp);
        end
    endtask

    // Combinational read: drive address, let it settle, then check it.
    task automatic rd(input logic [ADDR_W-1:0] a, input string tag);
        address = a;
        Dwr     = 1'b0;
        sb.push_back(model[a]);
        #1;
        compare(tag);
    endtask

    // One-cycle write. Before the edge, Rout must still show the old entry.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] d, input string tag);
        @(negedge clk);
        address = a;
        din     = d;
        Dwr     = 1'b1;
        sb.push_back(model[a]);
        #1;
        compare({tag, "_pre"});
        @(posedge clk);
        if (reset) model[a] = d;
        #1;
        Dwr = 1'b0;
        sb.push_back(model[a]);
        compare({tag, "_post"});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset   = 1'b0;
        address = '0;
        din     = '0;
        Dwr     = 1'b0;

        // Reset pulse, then sweep all entries with Dwr low.
        #12;
        rd(2'd1, "rst_low_a1");
        @(negedge clk);
        reset = 1'b1;
        rd(2'd0, "rst_a0");
        rd(2'd3, "rst_a3");
        rd(2'd1, "rst_a1");
        rd(2'd2, "rst_a2");

        // Single write, then read it back and read a neighbouring entry.
        wr(2'd1, 6'd9, "wr_a1_9");
        rd(2'd2, "rd_a2_zero");
        rd(2'd1, "rd_a1_9");

        // Dwr low for several edges with din=63 changes nothing.
        address = 2'd0;
        din     = 6'd63;
        Dwr     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back(model[0]);
        compare("nowrite_a0");

        // Fill the whole array on consecutive edges.
        wr(2'd0, 6'd63, "full_a0");
        wr(2'd1, 6'd1,  "full_a1");
        wr(2'd2, 6'd42, "full_a2");
        wr(2'd3, 6'd21, "full_a3");
        rd(2'd0, "full_rd_a0");
        rd(2'd1, "full_rd_a1");
        rd(2'd2, "full_rd_a2");
        rd(2'd3, "full_rd_a3");

        // Assert reset between edges. The clear must be visible at once.
        @(negedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rd(2'd0, "midrst_a0");
        rd(2'd1, "midrst_a1");
        rd(2'd2, "midrst_a2");
        rd(2'd3, "midrst_a3");

        // A write attempted while reset is low is ignored.
        wr(2'd2, 6'd55, "wr_in_rst");
        rd(2'd2, "rd_after_rst_wr");

        // The first write edge after reset release writes normally.
        @(negedge clk);
        reset = 1'b1;
        wr(2'd2, 6'd55, "wr_after_rel");
        rd(2'd0, "rel_a0_zero");
        rd(2'd2, "rel_a2_55");

        // Successive writes to one address: the last write wins.
        wr(2'd3, 6'd5, "ovr_5");
        wr(2'd3, 6'd7, "ovr_7");
        rd(2'd3, "ovr_rd_a3");
        rd(2'd2, "ovr_rd_a2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_m_tag
